// File: rtl/clkgen_pkg.sv
// rtl/clkgen_pkg.sv - shared types, defaults and alignment helper for the clock/phase generator
// Contents:
//   CNT_W_DEF   default divide/phase counter width
//   state_t     sequencer states HOLD / ALIGN / RUN
//   align_load  counter preload that puts a channel's period start PHASE edges late
package clkgen_pkg;

    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        ALIGN = 2'd1,
        RUN   = 2'd2
    } state_t;

    // Returns (div - ph) mod div with ph clamped to div-1. The caller must pass div >= 2.
    // (div - ph) is in 1..div, so the modulo only has to fold div itself back to 0.
    // That happens only when ph == 0, which avoids building a divider.
    function automatic int unsigned align_load(input int unsigned div, input int unsigned phase);
        int unsigned ph;
        ph = (phase >= div) ? div - 1 : phase;
        return (ph == 0) ? 0 : div - ph;
    endfunction

endpackage

// File: rtl/clkdiv_phase_gen_if.sv
// rtl/clkdiv_phase_gen_if.sv - runtime divide/phase configuration port
// Signals:
//   cfg_valid  request present
//   cfg_ready  generator can accept (only while running)
//   cfg_ch     target channel; one bit wider than needed so that out-of-range numbers can be sent and rejected
//   cfg_div    new divide ratio
//   cfg_phase  new phase delay in refclk cycles
//   cfg_err    one-cycle pulse when an accepted request was rejected
// Modports: master (requester), slave (generator)
interface clkdiv_phase_gen_if #(
    parameter int N_CH  = 2,
    parameter int CNT_W = clkgen_pkg::CNT_W_DEF
);
    localparam int CH_W = $clog2(N_CH + 1);

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_div;
    logic [CNT_W-1:0] cfg_phase;
    logic             cfg_err;

    modport master (
        output cfg_valid, cfg_ch, cfg_div, cfg_phase,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_div, cfg_phase,
        output cfg_ready, cfg_err
    );

endinterface

// File: rtl/clkdiv_chan.sv
// rtl/clkdiv_chan.sv - one divider channel: period counter plus registered outclk/clk_en
// Ports:
//   refclk, rst  clock and async active-high reset
//   load         preload the counter with load_val (alignment edge)
//   run          free-run the counter; when neither load nor run is set, the channel is cleared
//   div          divide ratio (>= 2)
//   load_val     preload value computed by the top
//   outclk       divided clock, high while the counter is below div/2
//   clk_en       one-cycle pulse when the counter reaches 0
module clkdiv_chan
    import clkgen_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             load,
    input  logic             run,
    input  logic [CNT_W-1:0] div,
    input  logic [CNT_W-1:0] load_val,
    output logic             outclk,
    output logic             clk_en
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] half;

    always_comb begin
        half     = div >> 1;
        // Compare with >= so that a counter beyond the end can never escape the wrap.
        cnt_next = (cnt >= div - CNT_W'(1)) ? '0 : cnt + CNT_W'(1);
    end

    // The outputs decode the counter value being written on this edge, so they stay registered and in step with cnt.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            outclk <= 1'b0;
            clk_en <= 1'b0;
        end else if (load) begin
            cnt    <= load_val;
            clk_en <= (load_val == '0);
            outclk <= (load_val < half);
        end else if (run) begin
            cnt    <= cnt_next;
            clk_en <= (cnt_next == '0);
            outclk <= (cnt_next < half);
        end else begin
            cnt    <= '0;
            outclk <= 1'b0;
            clk_en <= 1'b0;
        end
    end

endmodule

// File: rtl/clkdiv_phase_gen.sv
// rtl/clkdiv_phase_gen.sv - multi-channel divided clock / clock-enable generator with runtime reconfig
// Ports:
//   refclk   sole clock (50 MHz reference)
//   rst      asynchronous active-high reset
//   cfg      configuration port (slave side of clkdiv_phase_gen_if)
//   outclk   N_CH divided clocks (logic-generated; use as data/enable only)
//   clk_en   N_CH one-cycle enables, one per period at the phase point
//   locked   all channels aligned and running
module clkdiv_phase_gen
    import clkgen_pkg::*;
#(
    parameter int                    N_CH       = 2,
    parameter int                    CNT_W      = CNT_W_DEF,
    parameter int                    LOCK_CYC   = 16,
    parameter logic [N_CH*CNT_W-1:0] DIV_INIT   = {N_CH{8'd25}},
    parameter logic [N_CH*CNT_W-1:0] PHASE_INIT = {8'd6, 8'd0}
) (
    input  logic              refclk,
    input  logic              rst,
    clkdiv_phase_gen_if.slave cfg,
    output logic [N_CH-1:0]   outclk,
    output logic [N_CH-1:0]   clk_en,
    output logic              locked
);

    localparam int HOLD_W = $clog2(LOCK_CYC + 1);

    state_t            state;
    state_t            state_next;
    logic [HOLD_W-1:0] hold_cnt;
    logic              hold_done;
    logic              req;
    logic              req_legal;
    logic              accept;
    logic              load_en;
    logic              run_en;

    assign hold_done     = (hold_cnt == HOLD_W'(LOCK_CYC - 1));
    assign cfg.cfg_ready = (state == RUN);
    assign req           = cfg.cfg_valid && (state == RUN);
    assign req_legal     = (cfg.cfg_div >= CNT_W'(2)) && (32'(cfg.cfg_ch) < N_CH);
    assign accept        = req && req_legal;
    assign load_en       = (state == ALIGN);
    // A legal accept clears every channel on the same edge that the sequencer falls back to HOLD.
    assign run_en        = (state == RUN) && !accept;

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state <= HOLD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            HOLD:    if (hold_done) state_next = ALIGN;
            ALIGN:   state_next = RUN;
            RUN:     if (accept) state_next = HOLD;
            default: state_next = HOLD;
        endcase
    end

    // The counter idles at 0 outside HOLD, so every entry into HOLD starts a fresh count.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            hold_cnt <= '0;
        end else if ((state == HOLD) && !hold_done) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
        end else begin
            hold_cnt <= '0;
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            locked      <= 1'b0;
            cfg.cfg_err <= 1'b0;
        end else begin
            locked      <= load_en || run_en;
            cfg.cfg_err <= req && !req_legal;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        localparam logic [CNT_W-1:0] DIV_CFG = DIV_INIT[i*CNT_W +: CNT_W];
        localparam logic [CNT_W-1:0] DIV_RST = (DIV_CFG < CNT_W'(2)) ? CNT_W'(2) : DIV_CFG;
        localparam logic [CNT_W-1:0] PH_RST  = PHASE_INIT[i*CNT_W +: CNT_W];

        logic [CNT_W-1:0] div_r;
        logic [CNT_W-1:0] phase_r;
        logic [CNT_W-1:0] load_val;
        logic             sel;

        assign sel      = accept && (32'(cfg.cfg_ch) == i);
        assign load_val = CNT_W'(align_load(32'(div_r), 32'(phase_r)));

        always_ff @(posedge refclk or posedge rst) begin
            if (rst) begin
                div_r   <= DIV_RST;
                phase_r <= PH_RST;
            end else if (sel) begin
                div_r   <= cfg.cfg_div;
                phase_r <= cfg.cfg_phase;
            end
        end

        clkdiv_chan #(
            .CNT_W (CNT_W)
        ) u_chan (
            .refclk   (refclk),
            .rst      (rst),
            .load     (load_en),
            .run      (run_en),
            .div      (div_r),
            .load_val (load_val),
            .outclk   (outclk[i]),
            .clk_en   (clk_en[i])
        );
    end

endmodule
